// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
//
// Word-wide output path to a byte-oriented UART. CPU words are pushed into a
// small FIFO. A sequencer pops one word at a time and sends it as WORD_BYTES
// bytes. Before each byte it reads the UART status register. If the Tx-FIFO-full
// flag is set, it polls the status register again instead of writing. The core
// can therefore issue `out` back-to-back and stalls only when this FIFO is full.
//
// Parameters
//   WORD_BYTES    bytes per pushed word (1..8)
//   DEPTH         word FIFO depth (power of two, >= 2)
//   MSB_FIRST     0: byte 0 (bits 7:0) goes first, 1: top byte goes first
//   STAT_FULL_BIT bit of the status byte that flags "Tx FIFO full"
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   in_valid/in_ready   word push handshake, in_data carries the word
//   level               words waiting in the FIFO (word in flight excluded)
//   busy                FIFO non-empty or a word is being sent
//   uart_raddr/ren      status read request (address fixed at STAT_REG)
//   uart_rdone/rdata    status read completion pulse and status byte
//   uart_waddr/wen      byte write request (address fixed at TX_FIFO)
//   uart_wdata          byte being written, held until the next byte is latched
//   uart_wdone          byte write completion pulse
// -----------------------------------------------------------------------------
module uart_word_tx #(
  parameter int WORD_BYTES    = 4,
  parameter int DEPTH         = 4,
  parameter bit MSB_FIRST     = 1'b0,
  parameter int STAT_FULL_BIT = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*WORD_BYTES-1:0]      in_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy,
  output logic [3:0]                   uart_raddr,
  output logic                         uart_ren,
  input  logic                         uart_rdone,
  input  logic [7:0]                   uart_rdata,
  output logic [3:0]                   uart_waddr,
  output logic                         uart_wen,
  output logic [7:0]                   uart_wdata,
  input  logic                         uart_wdone
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_STAT  = 3'd1,
    WAIT_STAT = 3'd2,
    REQ_TX    = 3'd3,
    WAIT_TX   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  count_r;

  // Sequencer state
  state_t            state_r;
  logic [WORD_W-1:0] word_r;
  logic [IDX_W-1:0]  idx_r;
  logic              ren_r;
  logic              wen_r;
  logic [7:0]        wdata_r;

  logic              push_s;
  logic              pop_s;
  logic              stat_full_s;
  logic [WORD_W-1:0] head_s;
  logic              unused_rdata_s;

  // Selects the byte to send for position idx within the word. The order
  // depends on MSB_FIRST.
  function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
    int pos;
    pos = MSB_FIRST ? (WORD_BYTES - 1 - int'(i)) : int'(i);
    return w[8*pos +: 8];
  endfunction

  assign in_ready    = (count_r < DEPTH_LVL);
  assign push_s      = in_valid & in_ready;
  assign head_s      = mem_r[rd_ptr_r];
  assign stat_full_s = uart_rdata[STAT_FULL_BIT];
  // Only one status bit matters. The other bits are folded into a sink.
  assign unused_rdata_s = ^uart_rdata;

  assign level      = count_r;
  assign busy       = (count_r != {LVL_W{1'b0}}) | (state_r != IDLE);
  assign uart_raddr = 4'h8;
  assign uart_waddr = 4'h4;
  assign uart_ren   = ren_r;
  assign uart_wen   = wen_r;
  assign uart_wdata = wdata_r;

  // Pop decision: at the start of a word from IDLE, or on the final wdone
  // when another word is already waiting. The next word then starts without
  // passing through IDLE.
  always_comb begin
    pop_s = 1'b0;
    if (count_r == {LVL_W{1'b0}}) begin
      pop_s = 1'b0;
    end else if (state_r == IDLE) begin
      pop_s = 1'b1;
    end else if ((state_r == WAIT_TX) && uart_wdone && (idx_r == LAST_IDX)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Word FIFO: storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WORD_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Byte sequencer: status poll, byte latch, write strobe, per-byte advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      word_r  <= {WORD_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      ren_r   <= 1'b0;
      wen_r   <= 1'b0;
      wdata_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          ren_r <= 1'b0;
          wen_r <= 1'b0;
          if (pop_s) begin
            word_r  <= head_s;
            idx_r   <= {IDX_W{1'b0}};
            state_r <= REQ_STAT;
          end
        end
        REQ_STAT: begin
          ren_r   <= 1'b1;
          state_r <= WAIT_STAT;
        end
        WAIT_STAT: begin
          ren_r <= 1'b0;
          if (uart_rdone) begin
            if (stat_full_s) begin
              // UART Tx FIFO is full: poll again. No byte leaves here.
              state_r <= REQ_STAT;
            end else begin
              wdata_r <= pick_byte(word_r, idx_r);
              state_r <= REQ_TX;
            end
          end
        end
        REQ_TX: begin
          wen_r   <= 1'b1;
          state_r <= WAIT_TX;
        end
        WAIT_TX: begin
          wen_r <= 1'b0;
          if (uart_wdone) begin
            if (idx_r != LAST_IDX) begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= REQ_STAT;
            end else if (pop_s) begin
              word_r  <= head_s;
              idx_r   <= {IDX_W{1'b0}};
              state_r <= REQ_STAT;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          ren_r   <= 1'b0;
          wen_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
